// File: rtl/alu_pkg.sv
// alu_pkg: shared defaults and FSM encoding for the ALU command issuer.
//   DATA_W_DEF / SEL_W_DEF : default operand and select widths
//   state_e                : issuer FSM states (IDLE, SETTLE, HOLD)
//   cnt_w()                : width of a down-counter that must hold n
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: command storage for the issuer.
//   clk, rst       : clock, synchronous active-high reset
//   push, din      : write an entry (caller guarantees !full)
//   pop, dout      : drop the head; dout always shows the head (caller guarantees !empty)
//   full, empty    : occupancy flags; full is registered and held high in reset
//   level          : current occupancy, 0..DEPTH
module alu_cmd_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (pop && !push) level_nxt = level - 1'b1;
  end

  // full comes from next occupancy so it is a plain flop: no path from a
  // same-cycle pop to cmd_ready. Held high in reset so nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;   // pointers wrap naturally (DEPTH = 2^AW)
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives them onto a combinational ALU,
// waits SETTLE cycles, captures the result and holds it until accepted.
//   clk, rst                        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_a/b/sel: command input handshake
//   alu_a/alu_b/alu_sel             : registered operands to the ALU
//   alu_out/alu_cout                : ALU result back in
//   res_valid/res_ready, res_data/res_cout/res_sel : result handshake
//   fifo_level                      : command FIFO occupancy
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  input  logic [SEL_W-1:0]       cmd_sel,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic                   res_cout,
  output logic [SEL_W-1:0]       res_sel,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CW  = SEL_W + 2 * DATA_W;
  localparam int CNW = cnt_w(SETTLE);

  state_e         state;
  logic [CNW-1:0] cnt;
  logic           push, pop, full, empty;
  logic [CW-1:0]  head;

  assign push      = cmd_valid && cmd_ready;
  assign cmd_ready = !full;
  // Pop from IDLE, or straight out of HOLD on the accept cycle (back-to-back).
  assign pop       = !empty && ((state == ST_IDLE) || (state == ST_HOLD && res_ready));

  alu_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cmd_sel, cmd_a, cmd_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_sel   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {alu_sel, alu_a, alu_b} <= head;
            cnt   <= CNW'(SETTLE);
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNW'(1)) begin
            res_data  <= alu_out;
            res_cout  <= alu_cout;
            res_sel   <= alu_sel;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              {alu_sel, alu_a, alu_b} <= head;
              cnt   <= CNW'(SETTLE);
              state <= ST_SETTLE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed + randomized checks of alu_cmd_issuer with an
// adder standing in for the ALU and an in-order result scoreboard.
module tb_alu_cmd_issuer;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid, cmd_ready;
  logic [DATA_W-1:0]      cmd_a, cmd_b;
  logic [SEL_W-1:0]       cmd_sel;
  logic [DATA_W-1:0]      alu_a, alu_b, alu_out;
  logic [SEL_W-1:0]       alu_sel;
  logic                   alu_cout;
  logic                   res_valid, res_ready;
  logic [DATA_W-1:0]      res_data;
  logic                   res_cout;
  logic [SEL_W-1:0]       res_sel;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  // ALU stand-in: plain adder with carry.
  assign {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_cmd_issuer #(.DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .res_sel(res_sel),
    .fifo_level(fifo_level)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  logic [SEL_W+DATA_W:0] exp_q[$];   // {sel, cout, sum} in acceptance order
  int hs_cyc[$];                     // cycles on which a result was accepted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, res_valid, res_cout, res_sel, alu_sel, fifo_level}, 32'h0);
    chk({tag, "_dat"}, {alu_a, alu_b, res_data}, 32'h0);
  endtask

  // One clock: drive inputs, score handshakes seen before the edge, then
  // after the edge confirm a stalled result did not move.
  task automatic step(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [SEL_W-1:0] s, input logic rr);
    logic stall;
    logic [SEL_W+DATA_W:0] old, e;
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_sel = s; res_ready = rr;
    #1;
    if (!rst && cmd_valid && cmd_ready)
      exp_q.push_back({s, {1'b0, a} + {1'b0, b}});
    if (!rst && res_valid && res_ready) begin
      chk("res_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_value", {res_sel, res_cout, res_data}, e);
      end
      hs_cyc.push_back(cyc_n);
    end
    stall = !rst && res_valid && !res_ready;
    old   = {res_sel, res_cout, res_data};
    @(posedge clk);
    #1;
    cyc_n++;
    if (stall && !rst)
      chk("hold_stable", {res_valid, res_sel, res_cout, res_data}, {1'b1, old});
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, '0, '0, rr);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1'b1);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic ok;
    int pushed;
    logic v, rr;

    // ---- reset ----
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk_zero("reset");
    rst = 1'b0;
    idle(1'b0);
    chk("ready_after_reset", cmd_ready, 1);
    chk("level_after_reset", fifo_level, 0);

    // ---- single command, latency ----
    step(1'b1, 8'h05, 8'h04, 4'h1, 1'b0);           // push at t
    chk("alu_a_t1_not_yet", alu_a, 0);
    idle(1'b0);                                     // t+2
    chk("alu_ops_t2", {alu_sel, alu_a, alu_b}, {4'h1, 8'h05, 8'h04});
    chk("res_valid_t2_low", res_valid, 0);
    idle(1'b0);                                     // t+3
    chk("res_valid_t3", res_valid, 1);
    chk("res_t3", {res_sel, res_cout, res_data}, {4'h1, 1'b0, 8'h09});
    idle(1'b1);                                     // accept
    chk("res_valid_drop", res_valid, 0);
    idle(1'b0);
    idle(1'b0);
    chk("alu_hold_idle", {alu_sel, alu_a, alu_b}, {4'h1, 8'h05, 8'h04});

    // ---- carry out ----
    step(1'b1, 8'hFF, 8'h01, 4'h2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else idle(1'b0);
    end
    chk("carry_wait", ok, 1);
    chk("carry_res", {res_sel, res_cout, res_data}, {4'h2, 1'b1, 8'h00});
    drain("carry_drain");

    // ---- backpressure: 5 commands, FIFO fills ----
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", cmd_ready, 1);
      step(1'b1, 8'(8'h10 + i), 8'(8'h20 * i), 4'(i), 1'b0);
    end
    idle(1'b0);
    idle(1'b0);
    chk("bp_full_level", fifo_level, 4);
    chk("bp_ready_low", cmd_ready, 0);
    chk("bp_holding", res_valid, 1);
    drain("bp_drain");
    idle(1'b0);
    chk("bp_empty", {res_valid, fifo_level}, 0);

    // ---- streaming: 8 commands, results every SETTLE+1 cycles ----
    hs_cyc.delete();
    pushed = 0;
    for (int i = 0; i < 100 && pushed < 8; i++) begin
      v = cmd_ready;
      step(v, 8'($urandom), 8'($urandom), 4'($urandom), 1'b1);
      if (v) pushed++;
    end
    chk("stream_pushed", pushed, 8);
    drain("stream_drain");
    chk("stream_count", hs_cyc.size(), 8);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("stream_spacing", hs_cyc[i] - hs_cyc[i-1], SETTLE + 1);

    // ---- reset while holding a result with two queued ----
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 8'h01, 4'hA, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else idle(1'b0);
    end
    chk("rst_hold_reached", ok, 1);
    chk("rst_hold_level", fifo_level, 2);
    rst = 1'b1;
    idle(1'b0);
    exp_q.delete();
    chk_zero("rst_in_hold");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      chk("no_stale_res", res_valid, 0);
    end

    // ---- random traffic with random backpressure ----
    pushed = 0;
    for (int i = 0; i < 3000 && pushed < 100; i++) begin
      v  = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      if (v && cmd_ready) pushed++;
      step(v, 8'($urandom), 8'($urandom), 4'($urandom), rr);
    end
    chk("rand_pushed", pushed, 100);
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
